wb_arbiter: RTL and testbench

- Write-back stage and sole driver of the register file write port (write_reg, write_data, regWrite).
- Merges two result sources into one registered write per cycle:
  - the main pipeline MEM/WB path, which has priority and is never stalled here;
  - the multiply/divide unit, which writes late through a small in-order queue.
- Also performs MemtoReg selection and load byte/half extraction with sign/zero extension.

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_arbiter_chk.sv | 13 +
 rtl/wb_md_queue.sv | 99 +++++++++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: load-type encodings and
// default widths/depths used by the arbiter, its queue and its interface.
package wb_arbiter_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int QDEPTH_DEF     = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/mult-div producers and the write-back arbiter.
// The master side drives requests; the slave side is the arbiter.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_reg;
    logic [DATA_W-1:0] pipe_alu_result;
    logic [DATA_W-1:0] pipe_mem_data;
    logic              pipe_memtoreg;
    logic [2:0]        pipe_load_type;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_reg;
    logic [DATA_W-1:0] md_data;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              regWrite;
    logic              pipe_hold;
    logic [CW-1:0]     q_count;

    modport master (
        output pipe_valid, pipe_reg, pipe_alu_result, pipe_mem_data,
               pipe_memtoreg, pipe_load_type, md_valid, md_reg, md_data,
        input  md_ready, write_reg, write_data, regWrite, pipe_hold, q_count
    );

    modport slave (
        input  pipe_valid, pipe_reg, pipe_alu_result, pipe_mem_data,
               pipe_memtoreg, pipe_load_type, md_valid, md_reg, md_data,
        output md_ready, write_reg, write_data, regWrite, pipe_hold, q_count
    );

endinterface

// File: rtl/wb_arbiter_chk.sv
// Simulation checker: upstream must leave a bubble while pipe_hold is high,
// otherwise the starved queue head would be blocked again.
module wb_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic pipe_hold_i,
    input logic pipe_valid_i
);

    hold_bubble_a: assert property (@(posedge clk) disable iff (reset)
        pipe_hold_i |-> !pipe_valid_i);

endmodule

// File: rtl/wb_md_queue.sv
// In-order circular queue for late mult/div results. Each slot carries a dead
// bit so a younger pipeline write to the same register can cancel it in place.
module wb_md_queue
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF,
    localparam int CW    = $clog2(QDEPTH) + 1,
    localparam int PW    = $clog2(QDEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_reg_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [ADDR_W-1:0] kill_reg_i,
    output logic [ADDR_W-1:0] head_reg_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_dead_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [ADDR_W-1:0] reg_q   [QDEPTH];
    logic [DATA_W-1:0] data_q  [QDEPTH];
    logic [QDEPTH-1:0] valid_q;
    logic [QDEPTH-1:0] dead_q;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [QDEPTH-1:0] kill_hit_s;
    logic              push_ok_s, pop_ok_s;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(QDEPTH));
    assign count_o     = count_q;
    assign head_reg_o  = reg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign head_dead_o = dead_q[rd_ptr_q];
    assign push_ok_s   = push_i && !full_o;
    assign pop_ok_s    = pop_i && !empty_o;

    // Occupied slots whose destination matches the killing register
    always_comb begin
        kill_hit_s = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            kill_hit_s[i] = kill_i && valid_q[i] && (reg_q[i] == kill_reg_i);
        end
    end

    // Pointer and occupancy next state
    always_comb begin
        rd_ptr_d = pop_ok_s  ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
        wr_ptr_d = push_ok_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Slot storage; a same-cycle push lands after the kill so it survives
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            dead_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (kill_hit_s[i]) begin
                    dead_q[i] <= 1'b1;
                end
            end
            if (pop_ok_s) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push_ok_s) begin
                valid_q[wr_ptr_q] <= 1'b1;
                dead_q[wr_ptr_q]  <= 1'b0;
                reg_q[wr_ptr_q]   <= push_reg_i;
                data_q[wr_ptr_q]  <= push_data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: sole driver of the register-file write port. Pipeline
// results win each cycle; mult/div results drain from a queue in the gaps.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int QDEPTH     = QDEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DATA_W-1:0] pipe_wdata_s;
    logic              q_push_s, q_pop_s, q_kill_s;
    logic [ADDR_W-1:0] head_reg_s;
    logic [DATA_W-1:0] head_data_s;
    logic              head_dead_s;
    logic [CW-1:0]     q_count_s;
    logic              q_empty_s, q_full_s;
    logic [SW-1:0]     starve_inc_s;

    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic              pipe_hold_q, pipe_hold_d;
    logic [SW-1:0]     starve_q, starve_d;

    // Little-endian lane select; half loads ignore address bit 0
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic [2:0]        ltype
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (ltype)
            LD_B:    load_extract = {{(DATA_W-8){b[7]}}, b};
            LD_BU:   load_extract = {{(DATA_W-8){1'b0}}, b};
            LD_H:    load_extract = {{(DATA_W-16){h[15]}}, h};
            LD_HU:   load_extract = {{(DATA_W-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    assign pipe_wdata_s = bus.pipe_memtoreg
                        ? load_extract(bus.pipe_mem_data, bus.pipe_alu_result[1:0],
                                       bus.pipe_load_type)
                        : bus.pipe_alu_result;
    assign q_push_s     = bus.md_valid && !q_full_s;
    assign starve_inc_s = starve_q + SW'(1'b1);

    wb_md_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push_s),
        .push_reg_i  (bus.md_reg),
        .push_data_i (bus.md_data),
        .pop_i       (q_pop_s),
        .kill_i      (q_kill_s),
        .kill_reg_i  (bus.pipe_reg),
        .head_reg_o  (head_reg_s),
        .head_data_o (head_data_s),
        .head_dead_o (head_dead_s),
        .count_o     (q_count_s),
        .empty_o     (q_empty_s),
        .full_o      (q_full_s)
    );

    wb_arbiter_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .pipe_hold_i  (pipe_hold_q),
        .pipe_valid_i (bus.pipe_valid)
    );

    // Priority arbitration: pipeline, then queue head, then idle hold
    always_comb begin
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        q_pop_s      = 1'b0;
        q_kill_s     = 1'b0;
        if (bus.pipe_valid) begin
            write_reg_d  = bus.pipe_reg;
            write_data_d = pipe_wdata_s;
            reg_write_d  = (bus.pipe_reg != '0);
            q_kill_s     = (bus.pipe_reg != '0);
        end else if (!q_empty_s) begin
            q_pop_s      = 1'b1;
            write_reg_d  = head_reg_s;
            write_data_d = head_data_s;
            reg_write_d  = !head_dead_s && (head_reg_s != '0);
        end else begin
            reg_write_d  = 1'b0;
        end
    end

    // Starvation counter; hitting the limit requests a one-cycle bubble
    always_comb begin
        starve_d    = '0;
        pipe_hold_d = 1'b0;
        if (bus.pipe_valid && !q_empty_s) begin
            if (starve_inc_s == SW'(STARVE_MAX)) begin
                starve_d    = '0;
                pipe_hold_d = 1'b1;
            end else begin
                starve_d    = starve_inc_s;
            end
        end else begin
            starve_d    = '0;
        end
    end

    // Registered write port and hold request
    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            pipe_hold_q  <= 1'b0;
            starve_q     <= '0;
        end else begin
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            pipe_hold_q  <= pipe_hold_d;
            starve_q     <= starve_d;
        end
    end

    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.regWrite   = reg_write_q;
    assign bus.pipe_hold  = pipe_hold_q;
    assign bus.md_ready   = !q_full_s;
    assign bus.q_count    = q_count_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is
// driven and compared one cycle later against the register-file port.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
        logic        chk_rd;
    } exp_t;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    string tag_q[$];

    wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) bus ();

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_w(input string tag, input logic we, input logic [4:0] r,
                            input logic [31:0] d, input logic chk_rd);
        exp_t e;
        e.we = we; e.r = r; e.d = d; e.chk_rd = chk_rd;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance one clock, then retire one scoreboard entry if one is pending
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".we"}, {31'd0, bus.regWrite}, {31'd0, e.we});
            if (e.chk_rd) begin
                chk({t, ".reg"}, {27'd0, bus.write_reg}, {27'd0, e.r});
                chk({t, ".data"}, bus.write_data, e.d);
            end
        end
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] r, input logic [31:0] alu,
                              input logic m2r, input logic [2:0] lt);
        bus.pipe_valid      = v;
        bus.pipe_reg        = r;
        bus.pipe_alu_result = alu;
        bus.pipe_memtoreg   = m2r;
        bus.pipe_load_type  = lt;
    endtask

    task automatic drive_md(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.md_valid = v;
        bus.md_reg   = r;
        bus.md_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        bus.pipe_mem_data = 32'h80FF7F01;
        drive_md(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst.we", {31'd0, bus.regWrite}, 32'd0);
        chk("rst.reg", {27'd0, bus.write_reg}, 32'd0);
        chk("rst.data", bus.write_data, 32'd0);
        chk("rst.hold", {31'd0, bus.pipe_hold}, 32'd0);
        chk("rst.qcount", {30'd0, bus.q_count}, 32'd0);
        chk("rst.ready", {31'd0, bus.md_ready}, 32'd1);
        reset = 1'b0;

        // Plain ALU write, then register 0 suppressed
        drive_pipe(1'b1, 5'd5, 32'h1234, 1'b0, LD_W);
        expect_w("alu", 1'b1, 5'd5, 32'h1234, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd0, 32'h5678, 1'b0, LD_W);
        expect_w("r0", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();

        // Load extraction from 0x80FF7F01
        drive_pipe(1'b1, 5'd3, 32'd3, 1'b1, LD_B);
        expect_w("lb3", 1'b1, 5'd3, 32'hFFFFFF80, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd3, 32'd0, 1'b1, LD_B);
        expect_w("lb0", 1'b1, 5'd3, 32'h00000001, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd3, 32'd2, 1'b1, LD_BU);
        expect_w("lbu2", 1'b1, 5'd3, 32'h000000FF, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd3, 32'd2, 1'b1, LD_H);
        expect_w("lh2", 1'b1, 5'd3, 32'hFFFF80FF, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd3, 32'd1, 1'b1, LD_HU);
        expect_w("lhu1", 1'b1, 5'd3, 32'h00007F01, 1'b1);
        tick();
        drive_pipe(1'b1, 5'd3, 32'd0, 1'b1, 3'b111);
        expect_w("lt111", 1'b1, 5'd3, 32'h80FF7F01, 1'b1);
        tick();

        // Idle with empty queue holds the last reg/data
        drive_pipe(1'b0, 5'd9, 32'd0, 1'b0, LD_W);
        expect_w("idle", 1'b0, 5'd3, 32'h80FF7F01, 1'b1);
        tick();

        // Fill queue behind a busy pipeline; third offer is held
        drive_md(1'b1, 5'd8, 32'hA);
        drive_pipe(1'b1, 5'd1, 32'h101, 1'b0, LD_W);
        chk("fill.ready0", {31'd0, bus.md_ready}, 32'd1);
        expect_w("fill.p1", 1'b1, 5'd1, 32'h101, 1'b1);
        tick();
        drive_md(1'b1, 5'd9, 32'hB);
        drive_pipe(1'b1, 5'd2, 32'h102, 1'b0, LD_W);
        chk("fill.ready1", {31'd0, bus.md_ready}, 32'd1);
        expect_w("fill.p2", 1'b1, 5'd2, 32'h102, 1'b1);
        tick();
        chk("fill.q2", {30'd0, bus.q_count}, 32'd2);
        chk("fill.notready", {31'd0, bus.md_ready}, 32'd0);
        drive_md(1'b1, 5'd10, 32'hC);
        drive_pipe(1'b1, 5'd3, 32'h103, 1'b0, LD_W);
        expect_w("fill.p3", 1'b1, 5'd3, 32'h103, 1'b1);
        tick();
        chk("fill.held", {30'd0, bus.q_count}, 32'd2);
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("drain.8", 1'b1, 5'd8, 32'hA, 1'b1);
        tick();
        chk("drain.ready", {31'd0, bus.md_ready}, 32'd1);
        chk("drain.q1", {30'd0, bus.q_count}, 32'd1);
        expect_w("drain.9", 1'b1, 5'd9, 32'hB, 1'b1);
        tick();
        chk("pushpop.q1", {30'd0, bus.q_count}, 32'd1);
        drive_md(1'b0, 5'd0, 32'd0);
        expect_w("drain.10", 1'b1, 5'd10, 32'hC, 1'b1);
        tick();
        chk("drain.q0", {30'd0, bus.q_count}, 32'd0);

        // WAW: pipeline write to r7 kills queued r7
        drive_md(1'b1, 5'd7, 32'h11);
        drive_pipe(1'b1, 5'd4, 32'h44, 1'b0, LD_W);
        expect_w("waw.p4", 1'b1, 5'd4, 32'h44, 1'b1);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd7, 32'h22, 1'b0, LD_W);
        expect_w("waw.p7", 1'b1, 5'd7, 32'h22, 1'b1);
        tick();
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("waw.dead", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("waw.q0", {30'd0, bus.q_count}, 32'd0);

        // Same-cycle push of r7 survives the pipeline r7 write
        drive_md(1'b1, 5'd7, 32'h55);
        drive_pipe(1'b1, 5'd7, 32'h33, 1'b0, LD_W);
        expect_w("waw2.p7", 1'b1, 5'd7, 32'h33, 1'b1);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("waw2.alive", 1'b1, 5'd7, 32'h55, 1'b1);
        tick();

        // Queued write to r0 pops with regWrite low
        drive_md(1'b1, 5'd0, 32'h99);
        drive_pipe(1'b1, 5'd6, 32'h66, 1'b0, LD_W);
        expect_w("qr0.p6", 1'b1, 5'd6, 32'h66, 1'b1);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("qr0.pop", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk("qr0.q0", {30'd0, bus.q_count}, 32'd0);

        // Starvation: two entries queued, pipeline busy
        drive_md(1'b1, 5'd12, 32'hC0);
        drive_pipe(1'b1, 5'd1, 32'h200, 1'b0, LD_W);
        expect_w("st.s0", 1'b1, 5'd1, 32'h200, 1'b1);
        tick();
        drive_md(1'b1, 5'd13, 32'hD0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) drive_md(1'b0, 5'd0, 32'd0);
            drive_pipe(1'b1, 5'd1, 32'h200 + i, 1'b0, LD_W);
            expect_w("st.busy", 1'b1, 5'd1, 32'h200 + i, 1'b1);
            tick();
            chk($sformatf("st.hold%0d", i), {31'd0, bus.pipe_hold}, (i == 4) ? 32'd1 : 32'd0);
        end
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("st.bubble", 1'b1, 5'd12, 32'hC0, 1'b1);
        tick();
        chk("st.holdoff", {31'd0, bus.pipe_hold}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            drive_pipe(1'b1, 5'd2, 32'h300 + i, 1'b0, LD_W);
            expect_w("st2.busy", 1'b1, 5'd2, 32'h300 + i, 1'b1);
            tick();
            chk($sformatf("st2.hold%0d", i), {31'd0, bus.pipe_hold}, (i == 4) ? 32'd1 : 32'd0);
        end
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        expect_w("st2.bubble", 1'b1, 5'd13, 32'hD0, 1'b1);
        tick();

        // Reset mid-operation with a full queue and a write in flight
        drive_md(1'b1, 5'd20, 32'h1);
        drive_pipe(1'b1, 5'd1, 32'h301, 1'b0, LD_W);
        expect_w("rm.p1", 1'b1, 5'd1, 32'h301, 1'b1);
        tick();
        drive_md(1'b1, 5'd21, 32'h2);
        expect_w("rm.p1b", 1'b1, 5'd1, 32'h301, 1'b1);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd5, 32'h55, 1'b0, LD_W);
        expect_w("rm.flight", 1'b1, 5'd5, 32'h55, 1'b1);
        tick();
        chk("rm.q2", {30'd0, bus.q_count}, 32'd2);
        reset = 1'b1;
        drive_pipe(1'b1, 5'd6, 32'h66, 1'b0, LD_W);
        expect_w("rm.reset", 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        chk("rm.qcount", {30'd0, bus.q_count}, 32'd0);
        chk("rm.ready", {31'd0, bus.md_ready}, 32'd1);
        chk("rm.hold", {31'd0, bus.pipe_hold}, 32'd0);
        reset = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'd0, 1'b0, LD_W);
        for (int i = 0; i < 3; i++) begin
            expect_w("rm.idle", 1'b0, 5'd0, 32'd0, 1'b1);
            tick();
            chk("rm.idleq", {30'd0, bus.q_count}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
